// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequencer and valid/ready front-end for the iterative radix-4 long divider.
// Latency: normal divide ITER+3 cycles counting the accept edge; zero divisor, signed overflow, reuse hit 1 cycle.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready. Optional macro DIV_REUSE_EN.
module div_seq_ctrl #(
   parameter int ITER  = 16,
   parameter int CNT_W = 5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic        kill,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        busy,
   output logic [31:0] dp_dividend,
   output logic [31:0] dp_divisor,
   output logic        dp_unsign,
   output logic        dp_init,
   output logic        dp_advance,
   output logic        dp_last,
   input  logic [31:0] dp_quot,
   input  logic [31:0] dp_remd
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      ADV  = 3'd2,
      LAST = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t             state;
   logic [1:0]         op_r;
   logic [31:0]        rs1_r;
   logic [31:0]        rs2_r;
   logic [CNT_W-1:0]   cnt;

   // op encoding: bit 1 selects remainder, bit 0 selects unsigned
   logic               div_by_zero;
   logic               sgn_ovf;

   assign div_by_zero = (req_rs2 == 32'd0);
   assign sgn_ovf     = ~req_op[0] && (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);

   // Operands stay in the latched registers from accept through LAST, so the
   // datapath sees stable inputs for the whole iteration.
   assign dp_dividend = rs1_r;
   assign dp_divisor  = rs2_r;
   assign dp_unsign   = op_r[0];
   assign busy        = (state != IDLE);
   // kill has to block acceptance in the same cycle, hence combinational.
   assign req_ready   = (state == IDLE) && ~kill;

`ifdef DIV_REUSE_EN
   // Last completed normal-path result, keyed on operands and signedness.
   logic [31:0]        rq_quot;
   logic [31:0]        rq_remd;
   logic [31:0]        rq_rs1;
   logic [31:0]        rq_rs2;
   logic               rq_unsign;
   logic               rq_vld;
   logic               reuse_hit;

   assign reuse_hit = rq_vld && (rq_rs1 == req_rs1) && (rq_rs2 == req_rs2) &&
                      (rq_unsign == req_op[0]);

   // Reuse store: filled at LAST, invalidated at INIT and by kill mid-run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_quot   <= 32'd0;
         rq_remd   <= 32'd0;
         rq_rs1    <= 32'd0;
         rq_rs2    <= 32'd0;
         rq_unsign <= 1'b0;
         rq_vld    <= 1'b0;
      end else if (kill) begin
         if (state == INIT || state == ADV || state == LAST) begin
            rq_vld <= 1'b0;
         end
      end else if (state == INIT) begin
         rq_vld <= 1'b0;
      end else if (state == LAST) begin
         rq_quot   <= dp_quot;
         rq_remd   <= dp_remd;
         rq_rs1    <= rs1_r;
         rq_rs2    <= rs2_r;
         rq_unsign <= op_r[0];
         rq_vld    <= 1'b1;
      end
   end
`endif

   // Main FSM with registered strobes and response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_r       <= 2'd0;
         rs1_r      <= 32'd0;
         rs2_r      <= 32'd0;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_data  <= 32'd0;
         dp_init    <= 1'b0;
         dp_advance <= 1'b0;
         dp_last    <= 1'b0;
      end else if (kill) begin
         // Abort from any state; a pending response is withdrawn.
         state      <= IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         dp_init    <= 1'b0;
         dp_advance <= 1'b0;
         dp_last    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_r  <= req_op;
                  rs1_r <= req_rs1;
                  rs2_r <= req_rs2;
                  if (div_by_zero) begin
                     resp_data  <= req_op[1] ? req_rs1 : 32'hFFFF_FFFF;
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end else if (sgn_ovf) begin
                     resp_data  <= req_op[1] ? 32'd0 : 32'h8000_0000;
                     resp_valid <= 1'b1;
                     state      <= DONE;
`ifdef DIV_REUSE_EN
                  end else if (reuse_hit) begin
                     resp_data  <= req_op[1] ? rq_remd : rq_quot;
                     resp_valid <= 1'b1;
                     state      <= DONE;
`endif
                  end else begin
                     dp_init <= 1'b1;
                     state   <= INIT;
                  end
               end
            end
            INIT: begin
               dp_init    <= 1'b0;
               dp_advance <= 1'b1;
               cnt        <= '0;
               state      <= ADV;
            end
            ADV: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(ITER - 1)) begin
                  dp_advance <= 1'b0;
                  dp_last    <= 1'b1;
                  state      <= LAST;
               end
            end
            LAST: begin
               dp_last    <= 1'b0;
               resp_data  <= op_r[1] ? dp_remd : dp_quot;
               resp_valid <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural radix-4 datapath stand-in.
// Expected results and latencies are hand-computed constants.
// Build with +define+DIV_REUSE_EN to exercise the reuse path.
module tb_div_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = 2'd0;
   logic [31:0] req_rs1 = 32'd0;
   logic [31:0] req_rs2 = 32'd0;
   logic        kill = 1'b0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data;
   logic        busy;
   logic [31:0] dp_dividend;
   logic [31:0] dp_divisor;
   logic        dp_unsign;
   logic        dp_init;
   logic        dp_advance;
   logic        dp_last;
   logic [31:0] dp_quot = 32'hDEAD_BEEF;
   logic [31:0] dp_remd = 32'hDEAD_BEEF;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

`ifdef DIV_REUSE_EN
   localparam int REUSE_LAT = 1;
   localparam int REUSE_ADV = 0;
`else
   localparam int REUSE_LAT = 19;
   localparam int REUSE_ADV = 16;
`endif

   div_seq_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_rs1     (req_rs1),
      .req_rs2     (req_rs2),
      .kill        (kill),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_data   (resp_data),
      .busy        (busy),
      .dp_dividend (dp_dividend),
      .dp_divisor  (dp_divisor),
      .dp_unsign   (dp_unsign),
      .dp_init     (dp_init),
      .dp_advance  (dp_advance),
      .dp_last     (dp_last),
      .dp_quot     (dp_quot),
      .dp_remd     (dp_remd)
   );

   always #5 clk = ~clk;

   // Datapath stand-in: results form only when d_init is seen.
   always @(posedge clk) begin
      if (dp_init) begin
         if (dp_unsign) begin
            dp_quot <= dp_dividend / dp_divisor;
            dp_remd <= dp_dividend % dp_divisor;
         end else begin
            dp_quot <= 32'($signed(dp_dividend) / $signed(dp_divisor));
            dp_remd <= 32'($signed(dp_dividend) % $signed(dp_divisor));
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, measure latency/strobes, hold off resp_ready, then handshake.
   task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int exp_adv, input int hold);
      int lat;
      int nadv;
      int ninit;
      int nlast;
      check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
      req_op    = op;
      req_rs1   = a;
      req_rs2   = b;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      lat   = 1;
      nadv  = 0;
      ninit = 0;
      nlast = 0;
      while (!resp_valid && lat < 200) begin
         if (dp_advance) nadv++;
         if (dp_init) ninit++;
         if (dp_last) nlast++;
         tick();
         lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
      check({tag, ".data"}, resp_data, exp);
      check({tag, ".nadv"}, 32'(nadv), 32'(exp_adv));
      check({tag, ".ninit"}, 32'(ninit), (exp_adv != 0) ? 32'd1 : 32'd0);
      check({tag, ".nlast"}, 32'(nlast), (exp_adv != 0) ? 32'd1 : 32'd0);
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, ".hold_vld"}, 32'(resp_valid), 32'd1);
         check({tag, ".hold_data"}, resp_data, exp);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      check({tag, ".post_vld"}, 32'(resp_valid), 32'd0);
      check({tag, ".post_busy"}, 32'(busy), 32'd0);
      check({tag, ".post_rdy"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int nadv;
      int guard;

      // Reset values
      #12;
      check("rst.req_ready", 32'(req_ready), 32'd1);
      check("rst.resp_valid", 32'(resp_valid), 32'd0);
      check("rst.resp_data", resp_data, 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.strobes", {29'd0, dp_init, dp_advance, dp_last}, 32'd0);
      check("rst.dp_dividend", dp_dividend, 32'd0);
      check("rst.dp_divisor", dp_divisor, 32'd0);
      check("rst.dp_unsign", 32'(dp_unsign), 32'd0);
      rst_n = 1'b1;
      tick();

      // Normal path and signed/unsigned corners
      run_req("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 19, 16, 0);
      run_req("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 19, 16, 0);
      run_req("remu_m7_2", OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1, 19, 16, 0);
      run_req("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 19, 16, 0);

      // Special cases resolved without the datapath
      run_req("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
      run_req("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1, 0, 0);
      run_req("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
      run_req("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);

      // Backpressure: response held for 5 cycles
      run_req("div_hold", OP_DIV, 32'd100, 32'd7, 32'd14, 19, 16, 5);

      // Kill on the 8th advance cycle
      req_op    = OP_DIV;
      req_rs1   = 32'd1000;
      req_rs2   = 32'd3;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      nadv  = 0;
      guard = 0;
      while (nadv < 8 && guard < 50) begin
         if (dp_advance) nadv++;
         if (nadv < 8) tick();
         guard++;
      end
      check("kill.reached_adv8", 32'(nadv), 32'd8);
      kill = 1'b1;
      tick();
      kill = 1'b0;
      check("kill.busy", 32'(busy), 32'd0);
      check("kill.resp_valid", 32'(resp_valid), 32'd0);
      check("kill.strobes", {29'd0, dp_init, dp_advance, dp_last}, 32'd0);
      for (int i = 0; i < 15; i++) begin
         tick();
         check("kill.no_resp", 32'(resp_valid), 32'd0);
      end
      run_req("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 19, 16, 0);

      // Kill in IDLE blocks acceptance
      req_op    = OP_DIV;
      req_rs1   = 32'd5;
      req_rs2   = 32'd0;
      req_valid = 1'b1;
      kill      = 1'b1;
      #1;
      check("kill_idle.req_ready", 32'(req_ready), 32'd0);
      tick();
      req_valid = 1'b0;
      kill      = 1'b0;
      check("kill_idle.busy", 32'(busy), 32'd0);
      check("kill_idle.resp_valid", 32'(resp_valid), 32'd0);

      // Kill in DONE withdraws the response
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      check("kill_done.resp_valid", 32'(resp_valid), 32'd1);
      check("kill_done.req_ready", 32'(req_ready), 32'd0);
      kill       = 1'b1;
      resp_ready = 1'b1;
      tick();
      kill       = 1'b0;
      resp_ready = 1'b0;
      check("kill_done.withdrawn", 32'(resp_valid), 32'd0);
      check("kill_done.busy", 32'(busy), 32'd0);
      tick();
      check("kill_done.stays_low", 32'(resp_valid), 32'd0);

      // Reset in the middle of a run
      req_op    = OP_DIVU;
      req_rs1   = 32'd9;
      req_rs2   = 32'd3;
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check("mid_rst.busy_before", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst.busy", 32'(busy), 32'd0);
      check("mid_rst.strobes", {29'd0, dp_init, dp_advance, dp_last}, 32'd0);
      check("mid_rst.resp_data", resp_data, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Result reuse: DIV then REM with same operands; REMU differs in signedness
      run_req("reuse_div", OP_DIV, 32'd100, 32'd7, 32'd14, 19, 16, 0);
      run_req("reuse_rem", OP_REM, 32'd100, 32'd7, 32'd2, REUSE_LAT, REUSE_ADV, 0);
      run_req("reuse_remu", OP_REMU, 32'd100, 32'd7, 32'd2, 19, 16, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
